// File: rtl/router_input_ctrl.sv
// Router input port: sorts upstream flits into two VCs and arbitrates VC0/VC1/NI injection onto the switch.
// Latency: flit pushed at edge t drives the switch after edge t+1; NI injection drives it after one edge.
// Backpressure: in_ready drops while either VC is full; the VCs drain only when their consumer is ready.

module router_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is never reset; a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

module router_input_ctrl #(
    parameter logic [2:0] NODE_ID = 3'd0,
    parameter int         DEPTH   = 4,
    parameter int         CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_flit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    ni_tx_flit,
    input  logic          ni_tx_valid,
    output logic          ni_tx_ready,
    input  logic          down_ready,
    input  logic          ni_rx_ready,
    output logic [7:0]    vc0_out,
    output logic [7:0]    vc1_out,
    output logic [7:0]    ni_out,
    output logic          sel_NI_out,
    output logic          sel_vc,
    output logic          sel_up,
    output logic          down_valid,
    output logic          ni_rx_valid,
    output logic [CW-1:0] vc0_count,
    output logic [CW-1:0] vc1_count
);
    logic       accept;
    logic       to_vc0;
    logic [7:0] vc0_head;
    logic [7:0] vc1_head;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] rr;
    logic [1:0] rr_nxt;

    assign in_ready = rst && (vc0_count != CW'(DEPTH)) && (vc1_count != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign to_vc0   = (in_flit[7:5] == NODE_ID);

    router_vc_fifo #(.DEPTH(DEPTH), .W(8), .CW(CW)) u_vc0 (
        .clk      (clk),
        .rst      (rst),
        .push     (accept && to_vc0),
        .push_dat (in_flit),
        .pop      (gnt[0]),
        .head     (vc0_head),
        .count    (vc0_count)
    );

    router_vc_fifo #(.DEPTH(DEPTH), .W(8), .CW(CW)) u_vc1 (
        .clk      (clk),
        .rst      (rst),
        .push     (accept && !to_vc0),
        .push_dat (in_flit),
        .pop      (gnt[1]),
        .head     (vc1_head),
        .count    (vc1_count)
    );

    // Requests are masked during reset so nothing is granted or consumed from the NI.
    always_comb begin
        req[0] = rst && (vc0_count != '0) && ni_rx_ready;
        req[1] = rst && (vc1_count != '0) && down_ready;
        req[2] = rst && ni_tx_valid && down_ready;
    end

    always_comb begin
        gnt = 3'b000;
        case (rr)
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        rr_nxt = rr;
        if      (gnt[0]) rr_nxt = 2'd1;
        else if (gnt[1]) rr_nxt = 2'd2;
        else if (gnt[2]) rr_nxt = 2'd0;
    end

    assign ni_tx_ready = gnt[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr          <= 2'd0;
            sel_NI_out  <= 1'b0;
            sel_vc      <= 1'b0;
            sel_up      <= 1'b0;
            vc0_out     <= 8'h00;
            vc1_out     <= 8'h00;
            ni_out      <= 8'h00;
            down_valid  <= 1'b0;
            ni_rx_valid <= 1'b0;
        end else begin
            rr          <= rr_nxt;
            sel_NI_out  <= gnt[0];
            sel_vc      <= gnt[1] | gnt[2];
            sel_up      <= gnt[1];
            vc0_out     <= gnt[0] ? vc0_head : 8'h00;
            vc1_out     <= gnt[1] ? vc1_head : 8'h00;
            ni_out      <= gnt[2] ? ni_tx_flit : 8'h00;
            down_valid  <= gnt[1] | gnt[2];
            ni_rx_valid <= gnt[0];
        end
    end
endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed bench for router_input_ctrl (NODE_ID=2): expected switch outputs are queued
// by the stimulus and compared in order by a negedge monitor; counts/readies checked inline.
module tb_router_input_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ni_tx_flit;
    logic       ni_tx_valid;
    logic       ni_tx_ready;
    logic       down_ready;
    logic       ni_rx_ready;
    logic [7:0] vc0_out;
    logic [7:0] vc1_out;
    logic [7:0] ni_out;
    logic       sel_NI_out;
    logic       sel_vc;
    logic       sel_up;
    logic       down_valid;
    logic       ni_rx_valid;
    logic [2:0] vc0_count;
    logic [2:0] vc1_count;

    int checks = 0;
    int errors = 0;
    logic        mon_en = 1'b0;
    logic [28:0] exp_q[$];

    router_input_ctrl #(.NODE_ID(3'd2), .DEPTH(4), .CW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ni_tx_flit  (ni_tx_flit),
        .ni_tx_valid (ni_tx_valid),
        .ni_tx_ready (ni_tx_ready),
        .down_ready  (down_ready),
        .ni_rx_ready (ni_rx_ready),
        .vc0_out     (vc0_out),
        .vc1_out     (vc1_out),
        .ni_out      (ni_out),
        .sel_NI_out  (sel_NI_out),
        .sel_vc      (sel_vc),
        .sel_up      (sel_up),
        .down_valid  (down_valid),
        .ni_rx_valid (ni_rx_valid),
        .vc0_count   (vc0_count),
        .vc1_count   (vc1_count)
    );

    always #5 clk = ~clk;

    function automatic logic [28:0] mk(input logic [2:0] sel, input logic [7:0] v0,
                                       input logic [7:0] v1, input logic [7:0] ni,
                                       input logic dv, input logic nv);
        return {sel, v0, v1, ni, dv, nv};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid output must match the next queued expectation; idle cycles must be all zero.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [28:0] act;
            act = {sel_NI_out, sel_vc, sel_up, vc0_out, vc1_out, ni_out, down_valid, ni_rx_valid};
            if (down_valid === 1'b1 || ni_rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output at %0t", act, $time);
                end else begin
                    chk("switch_out", 32'(act), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("idle_out", 32'(act), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] f);
        bit done = 0;
        in_flit  = f;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", f);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        step();
    endtask

    initial begin
        int pulses;
        rst = 1'b0; in_valid = 1'b1; in_flit = 8'h45;
        ni_tx_valid = 1'b1; ni_tx_flit = 8'hAA;
        down_ready = 1'b1; ni_rx_ready = 1'b1;

        // 1. reset held two edges with traffic offered
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ni_tx_ready", 32'(ni_tx_ready), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_vc0_count", 32'(vc0_count), 32'd0);
        chk("rst_vc1_count", 32'(vc1_count), 32'd0);
        step();
        rst = 1'b1; in_valid = 1'b0; ni_tx_valid = 1'b0;
        down_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // 2. local flit ejected to NI
        exp_q.push_back(mk(3'b100, 8'h45, 8'h00, 8'h00, 1'b0, 1'b1));
        send(8'h45);
        @(negedge clk);
        chk("t2_vc0_count_1", 32'(vc0_count), 32'd1);
        step();
        @(negedge clk);
        chk("t2_vc0_count_0", 32'(vc0_count), 32'd0);
        drain();

        // 3. VC1 fills, fifth flit held, then drains in order
        for (int i = 1; i <= 4; i++) send(8'(i));
        in_flit = 8'h05; in_valid = 1'b1;
        @(negedge clk);
        chk("t3_vc1_full", 32'(vc1_count), 32'd4);
        chk("t3_in_ready_0", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t3_vc1_held", 32'(vc1_count), 32'd4);
        for (int i = 1; i <= 5; i++) exp_q.push_back(mk(3'b011, 8'h00, 8'(i), 8'h00, 1'b1, 1'b0));
        down_ready = 1'b1;
        send(8'h05);
        drain();
        chk("t3_vc1_empty", 32'(vc1_count), 32'd0);

        // 5. mid-operation reset discards VC1 contents (rr left at 1)
        down_ready = 1'b0;
        exp_q.push_back(mk(3'b100, 8'h4A, 8'h00, 8'h00, 1'b0, 1'b1));
        send(8'h4A);
        drain();
        ni_rx_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13);
        @(negedge clk);
        chk("t5_vc1_count_3", 32'(vc1_count), 32'd3);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_vc1_count_0", 32'(vc1_count), 32'd0);
        chk("t5_vc0_count_0", 32'(vc0_count), 32'd0);
        down_ready = 1'b1;
        repeat (4) step();

        // 4. round-robin from rr=0 across VC0, VC1 and NI injection
        down_ready = 1'b0; ni_rx_ready = 1'b0;
        send(8'h41); send(8'h42); send(8'h23);
        exp_q.push_back(mk(3'b100, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1));
        exp_q.push_back(mk(3'b011, 8'h00, 8'h23, 8'h00, 1'b1, 1'b0));
        exp_q.push_back(mk(3'b010, 8'h00, 8'h00, 8'hE7, 1'b1, 1'b0));
        exp_q.push_back(mk(3'b100, 8'h42, 8'h00, 8'h00, 1'b0, 1'b1));
        ni_tx_flit = 8'hE7; ni_tx_valid = 1'b1;
        ni_rx_ready = 1'b1; down_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ni_tx_ready) pulses++;
            step();
            if (pulses > 0) ni_tx_valid = 1'b0;
        end
        chk("t4_tx_ready_pulses", 32'(pulses), 32'd1);
        drain();

        // 6. push and pop on VC1 in the same cycle
        down_ready = 1'b0; ni_rx_ready = 1'b0;
        send(8'h31); send(8'h32);
        @(negedge clk);
        chk("t6_vc1_count_2", 32'(vc1_count), 32'd2);
        step();
        for (int i = 1; i <= 3; i++) exp_q.push_back(mk(3'b011, 8'h00, 8'(8'h30 + i), 8'h00, 1'b1, 1'b0));
        in_flit = 8'h33; in_valid = 1'b1; down_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_vc1_count_same", 32'(vc1_count), 32'd2);
        drain();
        chk("t6_vc1_empty", 32'(vc1_count), 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
